// File: rtl/aes_key_streamer_pkg.sv
// Shared types for the AES key streamer: control/flag records and FSM encoding.
// Build option AES_KEY_ZEROIZE_EN is consumed by aes_key_streamer.sv only.
package aes_key_streamer_pkg;

    localparam int unsigned KEY_WORDS     = 4;
    localparam int unsigned KS_NB_WIDTH   = 16;
    localparam int unsigned KS_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_LOAD,
        KS_REPLAY,
        KS_DONE
    } keystr_state_t;

    typedef struct packed {
        logic                   clear;
        logic                   start;
        logic [KS_NB_WIDTH-1:0] n_blocks;
    } ctrl_keystr_t;

    typedef struct packed {
        keystr_state_t          state;
        logic                   busy;
        logic                   done;
        logic [KS_NB_WIDTH-1:0] blocks_sent;
    } flags_keystr_t;

endpackage

// File: rtl/aes_key_streamer_if.sv
// Valid/ready word stream with byte strobes; master drives data, slave drives ready.
interface aes_key_streamer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport master (output valid, output data, output strb, input ready);
    modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/aes_key_streamer.sv
// Purpose: capture one 4-word AES-128 key, replay it once per block for n_blocks (0 = forever).
// Latency: first replayed word is valid the cycle after the 4th key word is accepted.
// Backpressure: key_o data/valid hold while !ready; key_i ready only in LOAD. Option: AES_KEY_ZEROIZE_EN.
module aes_key_streamer
    import aes_key_streamer_pkg::*;
#(
    parameter int unsigned NB_WIDTH   = KS_NB_WIDTH,
    parameter int unsigned DATA_WIDTH = KS_DATA_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    aes_key_streamer_if.slave   key_i,
    aes_key_streamer_if.master  key_o,
    input  ctrl_keystr_t        ctrl_i,
    output flags_keystr_t       flags_o
);

    localparam logic [1:0] WIDX_LAST = 2'(KEY_WORDS - 1);

    keystr_state_t                          state_q, state_d;
    logic [KEY_WORDS-1:0][DATA_WIDTH-1:0]   key_reg_q;
    logic [1:0]                             widx_q;
    logic [NB_WIDTH-1:0]                    block_cnt_q;
    logic [NB_WIDTH-1:0]                    n_blocks_q;

    logic key_hs;
    logic out_hs;
    logic last_block;
    logic unused_strb;

    assign key_i.ready = (state_q == KS_LOAD);
    assign key_o.valid = (state_q == KS_REPLAY);
    assign key_o.strb  = '1;
`ifdef AES_KEY_ZEROIZE_EN
    assign key_o.data  = (state_q == KS_REPLAY) ? key_reg_q[widx_q] : '0;
`else
    assign key_o.data  = key_reg_q[widx_q];
`endif

    assign key_hs      = key_i.valid && key_i.ready;
    assign out_hs      = key_o.valid && key_o.ready;
    // n_blocks of zero never terminates; only clear leaves REPLAY then
    assign last_block  = (n_blocks_q != '0) && (block_cnt_q == n_blocks_q - 1'b1);
    assign unused_strb = &{1'b0, key_i.strb};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= KS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            KS_IDLE:   if (ctrl_i.start) state_d = KS_LOAD;
            KS_LOAD:   if (key_hs && widx_q == WIDX_LAST) state_d = KS_REPLAY;
            KS_REPLAY: if (out_hs && widx_q == WIDX_LAST && last_block) state_d = KS_DONE;
            KS_DONE:   state_d = KS_IDLE;
            default:   state_d = KS_IDLE;
        endcase
        if (ctrl_i.clear) begin
            state_d = KS_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_reg_q   <= '0;
            widx_q      <= '0;
            block_cnt_q <= '0;
            n_blocks_q  <= '0;
        end else if (ctrl_i.clear) begin
            widx_q      <= '0;
            block_cnt_q <= '0;
`ifdef AES_KEY_ZEROIZE_EN
            key_reg_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                KS_IDLE: begin
                    if (ctrl_i.start) begin
                        n_blocks_q  <= ctrl_i.n_blocks;
                        block_cnt_q <= '0;
                        widx_q      <= '0;
                    end
                end
                KS_LOAD: begin
                    if (key_hs) begin
                        key_reg_q[widx_q] <= key_i.data;
                        widx_q            <= widx_q + 1'b1;
                    end
                end
                KS_REPLAY: begin
                    if (out_hs) begin
                        widx_q <= widx_q + 1'b1;
                        if (widx_q == WIDX_LAST && block_cnt_q != '1) begin
                            block_cnt_q <= block_cnt_q + 1'b1;
                        end
`ifdef AES_KEY_ZEROIZE_EN
                        if (state_d == KS_DONE) begin
                            key_reg_q <= '0;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign flags_o.state       = state_q;
    assign flags_o.busy        = (state_q != KS_IDLE);
    assign flags_o.done        = (state_q == KS_DONE);
    assign flags_o.blocks_sent = block_cnt_q;

endmodule
